// File: rtl/risc16_pkg.sv
// Shared RiSC-16 encodings: opcodes, ALU/mux selects and the control word
// consumed by both the decoder and the datapath.
package risc16_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_LW   = 3'b100,
        OP_SW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_NAND  = 2'b01,
        ALU_PASS1 = 2'b10,
        ALU_EQ    = 2'b11
    } alu_func_e;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_ALU    = 2'b10,
        PC_RSVD   = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        TGT_DMEM = 2'b00,
        TGT_ALU  = 2'b01,
        TGT_PC1  = 2'b10,
        TGT_RSVD = 2'b11
    } tgt_sel_e;

    localparam logic ALU1_RB     = 1'b0;
    localparam logic ALU1_LUIIMM = 1'b1;
    localparam logic ALU2_REG    = 1'b0;
    localparam logic ALU2_SIMM7  = 1'b1;
    localparam logic RF_RC       = 1'b0;
    localparam logic RF_RA       = 1'b1;

    typedef struct packed {
        alu_func_e func_alu;
        logic      mux_alu1;
        logic      mux_alu2;
        pc_sel_e   mux_pc;
        logic      mux_rf;
        tgt_sel_e  mux_tgt;
        logic      we_rf;
        logic      we_dmem;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Any instruction that steers the PC away from PC+1.
    function automatic logic is_redirect(input logic [2:0] op, input logic eq);
        return ((op == OP_BEQ) && eq) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational RiSC-16 opcode decode into the shared control word.
module control_decode
    import risc16_pkg::*;
(
    input  logic [2:0] op,
    input  logic       eq,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (op)
            OP_ADD: begin
                ctrl.func_alu = ALU_ADD;
                ctrl.mux_tgt  = TGT_ALU;
                ctrl.we_rf    = 1'b1;
            end
            OP_ADDI: begin
                ctrl.func_alu = ALU_ADD;
                ctrl.mux_alu2 = ALU2_SIMM7;
                ctrl.mux_tgt  = TGT_ALU;
                ctrl.we_rf    = 1'b1;
            end
            OP_NAND: begin
                ctrl.func_alu = ALU_NAND;
                ctrl.mux_tgt  = TGT_ALU;
                ctrl.we_rf    = 1'b1;
            end
            OP_LUI: begin
                ctrl.func_alu = ALU_PASS1;
                ctrl.mux_alu1 = ALU1_LUIIMM;
                ctrl.mux_tgt  = TGT_ALU;
                ctrl.we_rf    = 1'b1;
            end
            OP_LW: begin
                ctrl.func_alu = ALU_ADD;
                ctrl.mux_alu2 = ALU2_SIMM7;
                ctrl.mux_tgt  = TGT_DMEM;
                ctrl.we_rf    = 1'b1;
            end
            OP_SW: begin
                ctrl.func_alu = ALU_ADD;
                ctrl.mux_alu2 = ALU2_SIMM7;
                ctrl.mux_rf   = RF_RA;
                ctrl.mux_tgt  = TGT_DMEM;
                ctrl.we_dmem  = 1'b1;
            end
            OP_BEQ: begin
                ctrl.func_alu = ALU_EQ;
                ctrl.mux_pc   = eq ? PC_BRANCH : PC_INC;
                ctrl.mux_rf   = RF_RA;
            end
            OP_JALR: begin
                ctrl.func_alu = ALU_PASS1;
                ctrl.mux_pc   = PC_ALU;
                ctrl.mux_tgt  = TGT_PC1;
                ctrl.we_rf    = 1'b1;
            end
            // An unknown opcode matches no item and falls back to NOP.
            default: ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/control_decoder.sv
// RiSC-16 control decoder: reset-gated combinational decode plus a
// registered redirect flag and saturating redirect counter.
module control_decoder
    import risc16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op,
    input  logic        EQ,
    output logic [1:0]  FUNC_alu,
    output logic        MUX_alu1,
    output logic        MUX_alu2,
    output logic [1:0]  MUX_pc,
    output logic        MUX_rf,
    output logic [1:0]  MUX_tgt,
    output logic        WE_rf,
    output logic        WE_dmem,
    output logic        redirect_q,
    output logic [15:0] redirect_cnt
);

    ctrl_t ctrl_raw;
    ctrl_t ctrl;
    logic  redirect;

    control_decode u_decode (
        .op   (op),
        .eq   (EQ),
        .ctrl (ctrl_raw)
    );

    always_comb begin
        ctrl = rst ? CTRL_NOP : ctrl_raw;
    end

    assign FUNC_alu = ctrl.func_alu;
    assign MUX_alu1 = ctrl.mux_alu1;
    assign MUX_alu2 = ctrl.mux_alu2;
    assign MUX_pc   = ctrl.mux_pc;
    assign MUX_rf   = ctrl.mux_rf;
    assign MUX_tgt  = ctrl.mux_tgt;
    assign WE_rf    = ctrl.we_rf;
    assign WE_dmem  = ctrl.we_dmem;

    assign redirect = is_redirect(op, EQ);

    // Reset wins over a same-cycle redirect; the counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_q   <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            redirect_q <= redirect;
            if (redirect && (redirect_cnt != 16'hFFFF))
                redirect_cnt <= redirect_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_control_decoder.sv
// Directed bench for control_decoder: decode table, EQ sensitivity,
// reset gating, redirect flag/counter sequence and counter saturation.
module tb_control_decoder;

    logic        clk;
    logic        rst;
    logic [2:0]  op;
    logic        EQ;
    logic [1:0]  FUNC_alu;
    logic        MUX_alu1;
    logic        MUX_alu2;
    logic [1:0]  MUX_pc;
    logic        MUX_rf;
    logic [1:0]  MUX_tgt;
    logic        WE_rf;
    logic        WE_dmem;
    logic        redirect_q;
    logic [15:0] redirect_cnt;

    int n_chk;
    int n_err;

    control_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .EQ           (EQ),
        .FUNC_alu     (FUNC_alu),
        .MUX_alu1     (MUX_alu1),
        .MUX_alu2     (MUX_alu2),
        .MUX_pc       (MUX_pc),
        .MUX_rf       (MUX_rf),
        .MUX_tgt      (MUX_tgt),
        .WE_rf        (WE_rf),
        .WE_dmem      (WE_dmem),
        .redirect_q   (redirect_q),
        .redirect_cnt (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {FUNC_alu, MUX_alu1, MUX_alu2, MUX_pc, MUX_rf, MUX_tgt, WE_rf, WE_dmem}
    logic [10:0] dec;
    assign dec = {FUNC_alu, MUX_alu1, MUX_alu2, MUX_pc, MUX_rf, MUX_tgt, WE_rf, WE_dmem};

    logic [10:0] exp_tab [8];
    logic [10:0] d0;
    logic [10:0] d1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_tab[0] = 11'b00_0_0_00_0_01_1_0; // ADD
        exp_tab[1] = 11'b00_0_1_00_0_01_1_0; // ADDI
        exp_tab[2] = 11'b01_0_0_00_0_01_1_0; // NAND
        exp_tab[3] = 11'b10_1_0_00_0_01_1_0; // LUI
        exp_tab[4] = 11'b00_0_1_00_0_00_1_0; // LW
        exp_tab[5] = 11'b00_0_1_00_1_00_0_1; // SW
        exp_tab[6] = 11'b11_0_0_00_1_00_0_0; // BEQ, EQ=0
        exp_tab[7] = 11'b10_0_0_10_0_10_1_0; // JALR

        // Reset with SW and EQ=1 applied: decode forced to NOP, state cleared.
        rst = 1'b1;
        op  = 3'b101;
        EQ  = 1'b1;
        #1;
        chk("rst_dec_sw", 32'(dec), 32'h0);
        step();
        chk("rst_q", 32'(redirect_q), 32'h0);
        chk("rst_cnt", 32'(redirect_cnt), 32'h0);
        op = 3'b111;
        #1;
        chk("rst_dec_jalr", 32'(dec), 32'h0);
        step();

        // Full decode table with EQ=0.
        rst = 1'b0;
        EQ  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            #10;
            chk($sformatf("table_op%0d", i), 32'(dec), 32'(exp_tab[i]));
        end

        // BEQ: EQ only moves MUX_pc from 00 to 01.
        op = 3'b110;
        EQ = 1'b1;
        #1;
        chk("beq_eq1", 32'(dec), 32'(11'b11_0_0_01_1_00_0_0));

        // ADD and JALR ignore EQ.
        op = 3'b000; EQ = 1'b0; #1; d0 = dec;
        EQ = 1'b1; #1; d1 = dec;
        chk("add_eq_indep", 32'(d1), 32'(d0));
        chk("add_eq1_val", 32'(d1), 32'(exp_tab[0]));
        op = 3'b111; EQ = 1'b0; #1; d0 = dec;
        EQ = 1'b1; #1; d1 = dec;
        chk("jalr_eq_indep", 32'(d1), 32'(d0));
        chk("jalr_eq1_val", 32'(d1), 32'(exp_tab[7]));

        // Clear state, then JALR x3, ADD, BEQ taken.
        rst = 1'b1; op = 3'b000; EQ = 1'b0;
        step();
        rst = 1'b0; op = 3'b111;
        step(); chk("seq_cnt1", 32'(redirect_cnt), 32'd1); chk("seq_q1", 32'(redirect_q), 32'd1);
        step(); chk("seq_cnt2", 32'(redirect_cnt), 32'd2); chk("seq_q2", 32'(redirect_q), 32'd1);
        step(); chk("seq_cnt3", 32'(redirect_cnt), 32'd3); chk("seq_q3", 32'(redirect_q), 32'd1);
        op = 3'b000;
        step(); chk("seq_cnt4", 32'(redirect_cnt), 32'd3); chk("seq_q4", 32'(redirect_q), 32'd0);
        op = 3'b110; EQ = 1'b1;
        step(); chk("seq_cnt5", 32'(redirect_cnt), 32'd4); chk("seq_q5", 32'(redirect_q), 32'd1);

        // BEQ not taken does not count.
        EQ = 1'b0;
        step(); chk("beq_nt_cnt", 32'(redirect_cnt), 32'd4); chk("beq_nt_q", 32'(redirect_q), 32'd0);

        // Mid-stream reset with a simultaneous redirect: not counted.
        rst = 1'b1; op = 3'b111;
        step(); chk("mid_rst_cnt", 32'(redirect_cnt), 32'd0); chk("mid_rst_q", 32'(redirect_q), 32'd0);
        rst = 1'b0;
        #1;
        chk("resume_dec", 32'(dec), 32'(exp_tab[7]));
        step(); chk("resume_cnt", 32'(redirect_cnt), 32'd1);

        // Saturation: reach FFFE, then three more JALR.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre", 32'(redirect_cnt), 32'hFFFE);
        step(); chk("sat_1", 32'(redirect_cnt), 32'hFFFF);
        step(); chk("sat_2", 32'(redirect_cnt), 32'hFFFF);
        step(); chk("sat_3", 32'(redirect_cnt), 32'hFFFF);
        chk("sat_q", 32'(redirect_q), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/control_decoder.md
CONTROL_DECODER -- requirements
Module: control

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all registered state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 op  input  3  RiSC-16 opcode: ADD=000, ADDI=001, NAND=010, LUI=011, LW=100, SW=101, BEQ=110, JALR=111.
REQ-005 EQ  input  1  ALU equality flag; 1 = compared operands equal.
REQ-006 FUNC_alu  output  2  ALU function: 00 add, 01 nand, 10 pass src1, 11 equality compare.
REQ-007 MUX_alu1  output  1  ALU src1: 0 = register rB, 1 = LUI immediate (imm10 shifted left by 6).
REQ-008 MUX_alu2  output  1  ALU src2: 0 = register rC or rA, 1 = sign-extended imm7.
REQ-009 MUX_pc  output  2  next PC: 00 = PC+1, 01 = PC+1+simm7 (branch target), 10 = ALU result (jump), 11 unused.
REQ-010 MUX_rf  output  1  RF second read address: 0 = rC, 1 = rA.
REQ-011 MUX_tgt  output  2  RF write data: 00 = data memory, 01 = ALU, 10 = PC+1, 11 unused.
REQ-012 WE_rf  output  1  register-file write enable.
REQ-013 WE_dmem  output  1  data-memory write enable.
REQ-014 redirect_q  output  1  registered flag: previous cycle's decode changed PC flow.
REQ-015 redirect_cnt  output  16  registered count of PC redirects since reset.

Function
REQ-016 All decode outputs (REQ-006..013) SHALL be purely combinational from op, EQ and rst, with zero-cycle latency and no dependence on clk.
REQ-017 Decode table (FUNC_alu, MUX_alu1, MUX_alu2, MUX_pc, MUX_rf, MUX_tgt, WE_rf, WE_dmem) SHALL be:
- ADD: 00,0,0,00,0,01,1,0
- ADDI: 00,0,1,00,0,01,1,0
- NAND: 01,0,0,00,0,01,1,0
- LUI: 10,1,0,00,0,01,1,0
- LW: 00,0,1,00,0,00,1,0
- SW: 00,0,1,00,1,00,0,1
- BEQ: 11,0,0,{0,EQ},1,00,0,0
- JALR: 10,0,0,10,0,10,1,0
REQ-018 EQ SHALL affect only MUX_pc, and only when op=BEQ.
REQ-019 If op contains X/Z bits, all decode outputs SHALL take the safe NOP value: all fields 0.
REQ-020 While rst=1, the decode outputs SHALL be forced to the safe NOP value regardless of op and EQ.
REQ-021 redirect = (op==BEQ && EQ) || op==JALR, evaluated with rst low.
REQ-022 Each rising clk edge with rst=0: redirect_q <= redirect.
REQ-023 Each rising clk edge with rst=0: redirect_cnt increments by 1 when redirect=1, saturates at 16'hFFFF, and never wraps.

Reset
REQ-024 On a rising clk edge with rst=1: redirect_q <= 0 and redirect_cnt <= 0.
REQ-025 Reset takes priority over a simultaneous redirect event; that event is not counted.
REQ-026 Reset asserted mid-stream clears the state on the next edge; decode resumes on the first cycle rst=0.

Structure
REQ-027 Opcode constants and all mux/ALU-select encodings SHALL live in a shared package (risc16_pkg) used by the datapath too.
REQ-028 One sub-module is natural: control_decode (pure combinational op/EQ -> decode table); the top adds the rst gating and the redirect registers.

Verification
REQ-029 rst=0; step op through all 8 opcodes with EQ=0, checking after 10 ns -> each row of the REQ-017 table exactly (BEQ gives MUX_pc=00).
REQ-030 op=BEQ, EQ 0->1 -> MUX_pc 00->01; all other decode outputs unchanged.
REQ-031 op=ADD and op=JALR, each with EQ toggled -> decode outputs are identical for EQ=0 and EQ=1.
REQ-032 op=SW, rst=1 -> all decode outputs are 0; on the next clk edge redirect_q=0 and redirect_cnt=0.
REQ-033 3 clocks of JALR, then 1 of ADD, then 1 of BEQ with EQ=1 -> redirect_cnt = 1,2,3,3,4 after each successive edge; redirect_q = 1,1,1,0,1.
REQ-034 Preload redirect_cnt to FFFE via 65534 redirects, then 3 more JALR -> redirect_cnt holds at FFFF.
